// File: rtl/time_parameter_timer.sv
// time_parameter_timer
//   Stores NUM_PARAMS programmable interval lengths (each with a power-on
//   default), presents the one chosen by interval_code, and runs a countdown
//   timer that the traffic-light FSM starts with the selected interval.
//
// Ports
//   clk                      system clock
//   reset                    asynchronous active-low reset
//   prog_sync                one-cycle programming strobe (already synchronised)
//   time_parameter_selector  index of the parameter to program
//   time_value               value to program (0 restores the default)
//   interval_code            index to read out on value and to start the timer with
//   value                    stored value of param[interval_code], 0 if out of range
//   start_timer              load counter from param[interval_code] and start
//   one_hz_enable            one-cycle tick per second
//   remaining                current counter value
//   busy                     high while counting
//   expired                  one-cycle pulse when the interval ends
//   prog_err                 one-cycle pulse after a write to an out-of-range index
//
// Timer states
//   state  | meaning
//   IDLE   | no interval running, ticks ignored
//   COUNT  | counting down on one_hz_enable, busy high
//   EXPIRE | interval just ended, expired high for this one cycle
module time_parameter_timer #(
    parameter int NUM_PARAMS  = 3,
    parameter int SEL_WIDTH   = 2,
    parameter int VALUE_WIDTH = 4,
    parameter logic [NUM_PARAMS*VALUE_WIDTH-1:0] DEFAULTS = {4'd2, 4'd3, 4'd6}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prog_sync,
    input  logic [SEL_WIDTH-1:0]   time_parameter_selector,
    input  logic [VALUE_WIDTH-1:0] time_value,
    input  logic [SEL_WIDTH-1:0]   interval_code,
    output logic [VALUE_WIDTH-1:0] value,
    input  logic                   start_timer,
    input  logic                   one_hz_enable,
    output logic [VALUE_WIDTH-1:0] remaining,
    output logic                   busy,
    output logic                   expired,
    output logic                   prog_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [VALUE_WIDTH-1:0] remaining_next;
    logic [VALUE_WIDTH-1:0] param [NUM_PARAMS];
    logic                   sel_ok;

    // Read mux; codes with no stored parameter read as 0.
    always_comb begin
        value = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (interval_code == SEL_WIDTH'(i)) begin
                value = param[i];
            end
        end
    end

    always_comb begin
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (time_parameter_selector == SEL_WIDTH'(i)) begin
                sel_ok = 1'b1;
            end
        end
    end

    // Parameter store. A zero write restores the default so that no interval
    // can ever be programmed to zero length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                param[i] <= DEFAULTS[i*VALUE_WIDTH +: VALUE_WIDTH];
            end
            prog_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (prog_sync && (time_parameter_selector == SEL_WIDTH'(i))) begin
                    param[i] <= (time_value != '0) ? time_value
                                                   : DEFAULTS[i*VALUE_WIDTH +: VALUE_WIDTH];
                end
            end
            prog_err <= prog_sync && !sel_ok;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // A start always wins over a tick in the same cycle; value is the
    // registered parameter, so a same-edge write is not seen by the load.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        if (start_timer) begin
            remaining_next = value;
            state_next     = (value == '0) ? EXPIRE : COUNT;
        end else begin
            case (state)
                COUNT: begin
                    if (one_hz_enable) begin
                        if (remaining > VALUE_WIDTH'(1)) begin
                            remaining_next = remaining - VALUE_WIDTH'(1);
                        end else begin
                            remaining_next = '0;
                            state_next     = EXPIRE;
                        end
                    end
                end
                EXPIRE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy    = (state == COUNT);
    assign expired = (state == EXPIRE);

endmodule

// File: tb/tb_time_parameter_timer.sv
module tb_time_parameter_timer;

    localparam int NP = 3;
    localparam int SW = 2;
    localparam int VW = 4;
    localparam logic [NP*VW-1:0] DEF = {4'd2, 4'd3, 4'd6};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prog_sync = 1'b0;
    logic [SW-1:0] sel = '0;
    logic [VW-1:0] tv = '0;
    logic [SW-1:0] code = '0;
    logic          start_timer = 1'b0;
    logic          one_hz_enable = 1'b0;
    logic [VW-1:0] value;
    logic [VW-1:0] remaining;
    logic          busy;
    logic          expired;
    logic          prog_err;

    time_parameter_timer #(
        .NUM_PARAMS(NP), .SEL_WIDTH(SW), .VALUE_WIDTH(VW), .DEFAULTS(DEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .prog_sync(prog_sync),
        .time_parameter_selector(sel),
        .time_value(tv),
        .interval_code(code),
        .value(value),
        .start_timer(start_timer),
        .one_hz_enable(one_hz_enable),
        .remaining(remaining),
        .busy(busy),
        .expired(expired),
        .prog_err(prog_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VW-1:0] value;
        logic [VW-1:0] remaining;
        logic          busy;
        logic          expired;
        logic          prog_err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: an interval is a length plus a count of ticks seen.
    int m_param[NP];
    int m_len;
    int m_ticks;
    bit m_active;
    bit m_exp;
    bit m_err;

    function automatic int def_of(int i);
        logic [NP*VW-1:0] d;
        d = DEF;
        return int'(d[i*VW +: VW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_param[i] = def_of(i);
        m_len = 0; m_ticks = 0; m_active = 0; m_exp = 0; m_err = 0;
    endtask

    // Applies the effect of the clock edge that just saw the current inputs.
    task automatic model_edge();
        int load;
        if (!reset) return;
        load = (int'(code) < NP) ? m_param[int'(code)] : 0;
        m_exp = 0;
        if (start_timer) begin
            m_len = load;
            m_ticks = 0;
            m_active = (load != 0);
            m_exp = (load == 0);
        end else if (m_active && one_hz_enable) begin
            m_ticks++;
            if (m_ticks >= m_len) begin
                m_active = 0;
                m_exp = 1;
            end
        end
        m_err = 0;
        if (prog_sync) begin
            if (int'(sel) < NP)
                m_param[int'(sel)] = (tv != 0) ? int'(tv) : def_of(int'(sel));
            else
                m_err = 1;
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.value     = (int'(code) < NP) ? VW'(m_param[int'(code)]) : '0;
        e.remaining = m_active ? VW'(m_len - m_ticks) : '0;
        e.busy      = m_active;
        e.expired   = m_exp;
        e.prog_err  = m_err;
        return e;
    endfunction

    task automatic step(input bit r, input bit ps, input int s, input int v,
                        input int c, input bit st, input bit tk);
        @(posedge clk);
        #1;
        model_edge();
        reset         = r;
        prog_sync     = ps;
        sel           = s[SW-1:0];
        tv            = v[VW-1:0];
        code          = c[SW-1:0];
        start_timer   = st;
        one_hz_enable = tk;
        if (!r) model_reset();
        q.push_back(expect_now());
    endtask

    task automatic idle(input int c, input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, c, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("value",     int'(value),     int'(e.value));
            chk("remaining", int'(remaining), int'(e.remaining));
            chk("busy",      int'(busy),      int'(e.busy));
            chk("expired",   int'(expired),   int'(e.expired));
            chk("prog_err",  int'(prog_err),  int'(e.prog_err));
        end
    end

    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // reset release, defaults
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1, 1);
        idle(2, 1);
        idle(3, 1);

        // program and reset back to default
        step(1, 1, 2, 13, 2, 0, 0);
        idle(2, 2);
        step(0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 0, 0, 2, 0, 0);
        idle(2, 1);

        // zero substitution and out-of-range write
        step(1, 1, 1, 0, 1, 0, 0);
        idle(1, 1);
        step(1, 1, 3, 5, 0, 0, 0);
        idle(0, 1);
        idle(1, 1);
        idle(2, 1);
        idle(3, 1);

        // full countdown from 6 with ticks every 10 cycles
        step(1, 0, 0, 0, 0, 1, 0);
        for (int t = 0; t < 6; t++) begin
            idle(0, 9);
            step(1, 0, 0, 0, 0, 0, 1);
        end
        idle(0, 5);

        // programming during count, start+tick collision
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 9, 0, 1, 1);
        idle(0, 2);
        step(1, 0, 0, 0, 0, 1, 0);
        idle(0, 2);

        // reset mid-count at remaining=3
        step(1, 0, 0, 0, 0, 1, 0);
        for (int t = 0; t < 6; t++) step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int t = 0; t < 10; t++) step(1, 0, 0, 0, 0, 0, 1);

        // zero-length interval via out-of-range code
        step(1, 0, 0, 0, 3, 1, 0);
        idle(3, 3);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit r;
            bit ps;
            bit st;
            bit tk;
            int v;
            r  = ($urandom_range(0, 199) != 0);
            ps = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 2) == 0);
            v  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
            step(r, ps, int'($urandom_range(0, 3)), v, int'($urandom_range(0, 3)), st, tk);
        end

        step(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
